wb_ram_slave: RTL

Wishbone B4 pipelined-mode slave that terminates the data-port master and fronts a synchronous single-port RAM macro with fixed read latency. Handles accept/stall, programmable wait states, in-order ack/err return, outstanding-request limiting and cycle abort. Sits on the data bus between the core wrapper's Wishbone master port and on-chip data memory.

---
 rtl/wb_pkg.sv | 14 +
 rtl/wb_resp_pipe.sv | 34 +++
 rtl/wb_ram_slave.sv | 112 +++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone definitions for the data-port RAM slave and its response pipe.
package wb_pkg;

    localparam int WB_DW   = 32;
    localparam int WB_SELW = 4;

    // One in-flight response: whether it exists, whether it terminates with err, and its direction.
    typedef struct packed {
        logic valid;
        logic err;
        logic we;
    } resp_stage_t;

endpackage

// File: rtl/wb_resp_pipe.sv
// Fixed-depth response delay line: a response loaded on accept reaches the last stage
// exactly ReadLatency cycles later, preserving request order.
module wb_resp_pipe
    import wb_pkg::*;
#(
    parameter int ReadLatency = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  resp_stage_t load_data,
    input  logic        flush,
    input  logic        shift,
    output resp_stage_t last
);

    resp_stage_t stage [ReadLatency];

    // NOTE: the stages are a handful of flops, not a RAM, so every entry is cleared on reset and flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ReadLatency; i++) stage[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < ReadLatency; i++) stage[i] <= '0;
        end else if (shift) begin
            // NOTE: non-blocking updates let each stage take its neighbour's pre-edge value.
            stage[0] <= load ? load_data : '0;
            for (int i = 1; i < ReadLatency; i++) stage[i] <= stage[i-1];
        end
    end

    assign last = stage[ReadLatency-1];

endmodule

// File: rtl/wb_ram_slave.sv
// Wishbone B4 pipelined slave in front of a fixed-latency synchronous single-port RAM:
// wait-state stall, outstanding limit, range check, in-order ack/err and cycle abort.
module wb_ram_slave
    import wb_pkg::*;
#(
    parameter logic [31:0] BaseAddr       = 32'h0000_0000,
    parameter int          MemWords       = 4096,
    parameter int          ReadLatency    = 1,
    parameter int          WaitStates     = 0,
    parameter int          MaxOutstanding = 2,
    localparam int         AW             = $clog2(MemWords)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wb_cyc,
    input  logic               wb_stb,
    input  logic               wb_we,
    input  logic [WB_SELW-1:0] wb_sel,
    input  logic [31:0]        wb_adr,
    input  logic [WB_DW-1:0]   wb_dat_i,
    output logic [WB_DW-1:0]   wb_dat_o,
    output logic               wb_ack,
    output logic               wb_err,
    output logic               wb_stall,
    output logic               mem_en,
    output logic               mem_we,
    output logic [WB_SELW-1:0] mem_be,
    output logic [AW-1:0]      mem_addr,
    output logic [WB_DW-1:0]   mem_wdata,
    input  logic [WB_DW-1:0]   mem_rdata
);

    localparam int OW = $clog2(MaxOutstanding + 1);

    logic [2:0]    wait_cnt;
    logic [OW-1:0] outstanding;
    logic          wait_done;
    logic          full;
    logic          accept;
    logic          in_range;
    logic          resp_exit;
    logic [31:0]   offset;
    logic [31:0]   word_idx;
    resp_stage_t   load_data;
    resp_stage_t   last;

    // Range check on the word index; the byte lane bits of wb_adr drop out in the shift.
    assign offset   = wb_adr - BaseAddr;
    assign word_idx = offset >> 2;
    assign in_range = (wb_adr >= BaseAddr) && (word_idx < 32'(MemWords));

    // Stall depends only on registered state so the master never sees an address-dependent stall.
    assign wait_done = (wait_cnt == 3'(WaitStates));
    assign full      = (outstanding == OW'(MaxOutstanding));
    assign wb_stall  = wb_cyc & wb_stb & (~wait_done | full);
    assign accept    = wb_cyc & wb_stb & ~wb_stall;

    assign mem_en    = accept & in_range;
    assign mem_we    = wb_we;
    assign mem_be    = wb_sel;
    assign mem_addr  = word_idx[AW-1:0];
    assign mem_wdata = wb_dat_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (!wb_cyc || accept) begin
            wait_cnt <= '0;
        end else if (wb_stb && wb_stall && !wait_done) begin
            wait_cnt <= wait_cnt + 3'd1;
        end
    end

    assign resp_exit = last.valid;

    // Abort drops every pending response, so the count restarts from zero with the next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
        end else if (!wb_cyc) begin
            outstanding <= '0;
        end else if (accept && !resp_exit) begin
            outstanding <= outstanding + OW'(1);
        end else if (!accept && resp_exit) begin
            outstanding <= outstanding - OW'(1);
        end
    end

    assign load_data = '{valid: 1'b1, err: ~in_range, we: wb_we};

    wb_resp_pipe #(
        .ReadLatency(ReadLatency)
    ) u_resp_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .load_data(load_data),
        .flush    (~wb_cyc),
        .shift    (1'b1),
        .last     (last)
    );

    assign wb_ack = last.valid & ~last.err & wb_cyc;
    assign wb_err = last.valid &  last.err & wb_cyc;

    // NOTE: default assignment first keeps this block free of inferred latches.
    always_comb begin
        wb_dat_o = '0;
        if (wb_ack && !last.we) wb_dat_o = mem_rdata;
    end

endmodule
